// File: rtl/row_reduce_pkg.sv
// Shared definitions for the row reducer: tree depth helper, FSM encoding, saturation modes.
package row_reduce_pkg;

  localparam int SAT_WRAP  = 0;
  localparam int SAT_CLAMP = 1;

  typedef enum logic {
    IDLE = 1'b0,
    OPEN = 1'b1
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/adder_tree_pipe.sv
// Registered pairwise reduction of NI signed lanes; level k results are DATA_W+k+1 bits wide.
module adder_tree_pipe
  import row_reduce_pkg::*;
#(
  parameter int NI     = 8,
  parameter int DATA_W = 32
) (
  input  logic                                               clk,
  input  logic                                               rst,
  input  logic                                               flush,
  input  logic                                               in_valid,
  input  logic                                               in_last,
  input  logic [NI*DATA_W-1:0]                               in_row,
  output logic                                               out_valid,
  output logic                                               out_last,
  output logic signed [DATA_W+row_reduce_pkg::clog2(NI)-1:0] out_sum
);

  localparam int LVL = clog2(NI);

  logic [LVL-1:0] vld_sr;
  logic [LVL-1:0] last_sr;

  for (genvar k = 0; k < LVL; k++) begin : g_lvl
    localparam int N = NI >> (k + 1);
    localparam int W = DATA_W + k + 1;
    logic signed [W-1:0] s [N];

    if (k == 0) begin : g_first
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int j = 0; j < N; j++) s[j] <= '0;
        end else begin
          for (int j = 0; j < N; j++)
            s[j] <= W'($signed(in_row[2*j*DATA_W +: DATA_W]))
                  + W'($signed(in_row[(2*j+1)*DATA_W +: DATA_W]));
        end
      end
    end else begin : g_next
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int j = 0; j < N; j++) s[j] <= '0;
        end else begin
          for (int j = 0; j < N; j++)
            s[j] <= W'(g_lvl[k-1].s[2*j]) + W'(g_lvl[k-1].s[2*j+1]);
        end
      end
    end
  end

  // Sideband only; tree data need not be flushed since nothing downstream looks at it unqualified.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_sr  <= '0;
      last_sr <= '0;
    end else if (flush) begin
      vld_sr  <= '0;
      last_sr <= '0;
    end else begin
      vld_sr[0]  <= in_valid;
      last_sr[0] <= in_valid & in_last;
      for (int i = 1; i < LVL; i++) begin
        vld_sr[i]  <= vld_sr[i-1];
        last_sr[i] <= last_sr[i-1];
      end
    end
  end

  assign out_valid = vld_sr[LVL-1];
  assign out_last  = last_sr[LVL-1];
  assign out_sum   = g_lvl[LVL-1].s[0];

endmodule

// File: rtl/row_reduce_accumulator.sv
// Adder-tree row reducer with per-row chunk accumulation and wrap/saturate output stage.
// state | meaning
// IDLE  | no row open; next tree result starts a row
// OPEN  | row in progress; tree results accumulate until last
module row_reduce_accumulator
  import row_reduce_pkg::*;
#(
  parameter int NI     = 8,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16,
  parameter int SAT    = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic                 in_last,
  input  logic [NI*DATA_W-1:0] in_row,
  input  logic                 abort,
  output logic                 out_valid,
  output logic [DATA_W-1:0]    out_sum,
  output logic [CNT_W-1:0]     out_count,
  output logic                 out_ovf
);

  localparam int LVL   = clog2(NI);
  localparam int TW    = DATA_W + LVL;
  localparam int ACC_W = DATA_W + LVL + CNT_W;

  localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic                 t_valid, t_last;
  logic signed [TW-1:0] t_sum;

  state_t                  state, state_n;
  logic signed [ACC_W-1:0] acc, acc_n;
  logic [CNT_W-1:0]        cnt, cnt_n;
  logic                    emit, hi, lo;
  logic [DATA_W-1:0]       sum_sel;

  adder_tree_pipe #(.NI(NI), .DATA_W(DATA_W)) u_tree (
    .clk       (clk),
    .rst       (rst),
    .flush     (abort),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_row    (in_row),
    .out_valid (t_valid),
    .out_last  (t_last),
    .out_sum   (t_sum)
  );

  always_comb begin
    state_n = state;
    acc_n   = acc;
    cnt_n   = cnt;
    emit    = 1'b0;
    if (t_valid) begin
      case (state)
        IDLE: begin
          acc_n = ACC_W'(t_sum);
          cnt_n = CNT_W'(1);
          if (t_last) emit = 1'b1;
          else        state_n = OPEN;
        end
        OPEN: begin
          acc_n = acc + ACC_W'(t_sum);
          cnt_n = (cnt == '1) ? cnt : cnt + CNT_W'(1);
          if (t_last) begin
            emit    = 1'b1;
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Range check is on the updated accumulator so the emitted total includes the last chunk.
  always_comb begin
    hi      = (acc_n > MAX_V);
    lo      = (acc_n < MIN_V);
    sum_sel = acc_n[DATA_W-1:0];
    if (SAT == SAT_CLAMP) begin
      if (hi)      sum_sel = MAX_V[DATA_W-1:0];
      else if (lo) sum_sel = MIN_V[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else if (abort) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_n;
      acc       <= acc_n;
      cnt       <= cnt_n;
      out_valid <= emit;
      if (emit) begin
        out_sum   <= sum_sel;
        out_count <= cnt_n;
        out_ovf   <= hi | lo;
      end
    end
  end

endmodule

// File: tb/tb_row_reduce_accumulator.sv
// Randomized and directed bench for row_reduce_accumulator, wrap and clamp instances side by side.
module tb_row_reduce_accumulator;

  localparam int NI = 8, DW = 32, CW = 16, LVL = 3;

  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_last = 1'b0, abort = 1'b0;
  logic [NI*DW-1:0] in_row = '0;
  logic          v0, v1, f0, f1;
  logic [DW-1:0] s0, s1;
  logic [CW-1:0] c0, c1;

  row_reduce_accumulator #(.NI(NI), .DATA_W(DW), .CNT_W(CW), .SAT(0)) u_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last), .in_row(in_row),
    .abort(abort), .out_valid(v0), .out_sum(s0), .out_count(c0), .out_ovf(f0));
  row_reduce_accumulator #(.NI(NI), .DATA_W(DW), .CNT_W(CW), .SAT(1)) u_clamp (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last), .in_row(in_row),
    .abort(abort), .out_valid(v1), .out_sum(s1), .out_count(c1), .out_ovf(f1));

  always #5 clk = ~clk;

  typedef struct { longint sum; bit last; int cyc; } chunk_t;

  chunk_t q[$];
  bit     m_open;
  longint m_acc;
  int     m_cnt, cyc, n_total, n_bad;
  bit     e_valid, e_ovf;
  logic [DW-1:0] e_sum0, e_sum1;
  int     e_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic longint lane_sum(input logic [NI*DW-1:0] row);
    longint s = 0;
    for (int i = 0; i < NI; i++) s += longint'($signed(row[i*DW +: DW]));
    return s;
  endfunction

  function automatic logic [NI*DW-1:0] row_const(input int val);
    logic [NI*DW-1:0] r;
    for (int i = 0; i < NI; i++) r[i*DW +: DW] = val;
    return r;
  endfunction

  task automatic model_clear();
    q.delete();
    m_open = 0; m_acc = 0; m_cnt = 0;
  endtask

  task automatic apply(input chunk_t c);
    if (!m_open) begin
      m_acc = c.sum; m_cnt = 1;
    end else begin
      m_acc += c.sum;
      m_cnt = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
    end
    m_open = !c.last;
    if (c.last) begin
      e_valid = 1;
      e_cnt   = m_cnt;
      e_ovf   = (m_acc > 64'sd2147483647) || (m_acc < -64'sd2147483648);
      e_sum0  = m_acc[DW-1:0];
      if (m_acc > 64'sd2147483647)       e_sum1 = 32'h7FFF_FFFF;
      else if (m_acc < -64'sd2147483648) e_sum1 = 32'h8000_0000;
      else                               e_sum1 = m_acc[DW-1:0];
    end
  endtask

  // Called at a negedge: check what the DUT shows now, then present this cycle's inputs.
  task automatic step(input bit v, input bit l, input logic [NI*DW-1:0] row, input bit ab);
    chunk_t c;
    check("valid_wrap", v0, e_valid);
    check("valid_clamp", v1, e_valid);
    check("sum_wrap", s0, e_sum0);
    check("sum_clamp", s1, e_sum1);
    check("count_wrap", c0, e_cnt);
    check("count_clamp", c1, e_cnt);
    check("ovf_wrap", f0, e_ovf);
    check("ovf_clamp", f1, e_ovf);
    in_valid = v; in_last = l; in_row = row; abort = ab;
    e_valid = 0;
    if (ab) model_clear();
    else begin
      if (q.size() > 0 && q[0].cyc == cyc - LVL) begin
        c = q.pop_front();
        apply(c);
      end
      if (v) q.push_back('{lane_sum(row), l, cyc});
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, 0);
  endtask

  task automatic do_reset();
    rst = 1; in_valid = 0; in_last = 0; abort = 0;
    model_clear();
    e_valid = 0; e_sum0 = 0; e_sum1 = 0; e_cnt = 0; e_ovf = 0;
    @(negedge clk);
    check("rst_valid", v0, 0);
    check("rst_sum", s0, 0);
    rst = 0;
  endtask

  initial begin
    logic [NI*DW-1:0] r;
    n_total = 0; n_bad = 0; cyc = 0;
    model_clear();
    e_valid = 0; e_sum0 = 0; e_sum1 = 0; e_cnt = 0; e_ovf = 0;
    repeat (2) @(negedge clk);
    rst = 0;

    // 1: lanes 1..8 single chunk
    for (int i = 0; i < NI; i++) r[i*DW +: DW] = i + 1;
    step(1, 1, r, 0);
    step(0, 0, '0, 0); step(0, 0, '0, 0); step(0, 0, '0, 0);
    check("t1_pulse", v0, 1);
    check("t1_sum", s0, 36);
    check("t1_count", c0, 1);
    idle(2);

    // 2: three-chunk row then back-to-back single chunk
    step(1, 0, row_const(1), 0);
    step(1, 0, row_const(1), 0);
    step(1, 1, row_const(1), 0);
    step(1, 1, row_const(2), 0);
    idle(6);
    check("t2_sum", s0, 16);
    check("t2_count", c0, 1);

    // 3: alternating -5/3 with a gap
    for (int i = 0; i < NI; i++) r[i*DW +: DW] = (i % 2 == 0) ? -5 : 3;
    step(1, 0, r, 0);
    idle(3);
    step(1, 1, r, 0);
    idle(5);
    check("t3_sum", s0, 32'hFFFF_FFF0);
    check("t3_count", c0, 2);

    // 4: overflow, wrap vs clamp
    step(1, 1, row_const(32'h7FFF_FFFF), 0);
    idle(5);
    check("t4_wrap", s0, 32'hFFFF_FFF8);
    check("t4_clamp", s1, 32'h7FFF_FFFF);
    check("t4_ovf", f0 & f1, 1);

    // 5: reset mid-row
    step(1, 0, row_const(1), 0);
    step(1, 0, row_const(1), 0);
    step(0, 0, '0, 0);
    do_reset();
    idle(4);
    step(1, 1, row_const(1), 0);
    idle(5);
    check("t5_sum", s0, 8);

    // 6: abort drops an in-flight row
    step(1, 1, row_const(3), 0);
    step(0, 0, '0, 0);
    step(0, 0, '0, 1);
    idle(5);
    check("t6_hold", s0, 8);
    step(1, 1, row_const(1), 0);
    idle(5);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      bit big;
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
        continue;
      end
      big = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < NI; i++)
        r[i*DW +: DW] = big ? $urandom : DW'(int'($urandom_range(0, 40)) - 20);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, r,
           $urandom_range(0, 49) == 0);
    end
    idle(6);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
